// File: rtl/cpu_defs.sv
// Shared encodings for the hardwired control unit: opcodes, ALU select codes,
// T-state enumeration and small decode helpers.
package cpu_defs;

  localparam int NUM_REGS = 16;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  function automatic logic op_defined(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_MUL, OP_DIV,
      OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: op_defined = 1'b1;
      default:                           op_defined = 1'b0;
    endcase
  endfunction

  // Address arithmetic (ld/st/addi) always uses ADD.
  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_MUL:  alu_code = ALU_MUL;
      OP_DIV:  alu_code = ALU_DIV;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_select_encode.sv
// Register select/encode: picks Ra/Rb/Rc from the IR register fields and turns
// it into one-hot Rin/Rout enables. Purely combinational.
module select_encode
  import cpu_defs::*;
(
  input  logic [11:0]          regs,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 rin,
  input  logic                 rout,
  output logic [NUM_REGS-1:0]  rin_vec,
  output logic [NUM_REGS-1:0]  rout_vec
);

  logic [3:0]          sel;
  logic                hit;
  logic [NUM_REGS-1:0] dec;

  // gra > grb > grc priority; the sequencer never raises more than one.
  assign sel = gra ? regs[11:8] : grb ? regs[7:4] : regs[3:0];
  assign hit = gra | grb | grc;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
    assign dec[i] = hit && (sel == 4'(i));
  end

  assign rin_vec  = rin  ? dec : '0;
  assign rout_vec = rout ? dec : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: walks fetch/execute T-states for the opcode in IR
// and drives every datapath strobe plus the memory read/write handshake.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_done,
  input  logic        stop,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Cout,
  output logic [3:0]  ALUselect,
  output logic        mem_read,
  output logic        mem_write,
  output logic        run,
  output logic        illegal
);

  state_t      state, next;
  state_t      fetch_next;
  logic [4:0]  op;
  logic        alu_rr, alu_imm, muldiv, mem_op;
  logic        waiting, wait_ovf, ovf_q;
  logic [31:0] wait_cnt;
  logic        gra, grb, grc, rin_en, rout_en;
  logic [14:0] unused_ir_bits;

  assign op             = IR[31:27];
  assign unused_ir_bits = IR[14:0];
  assign alu_rr         = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign alu_imm        = (op == OP_ADDI);
  assign muldiv         = (op == OP_MUL) || (op == OP_DIV);
  assign mem_op         = (op == OP_LD) || (op == OP_ST);

  // Every return to fetch honours a pending halt request.
  assign fetch_next = stop ? S_HALT : S_T0;

  assign waiting  = (state == S_T1) || (state == S_T6 && op == OP_LD) ||
                    (state == S_T7 && op == OP_ST);
  assign wait_ovf = (MEM_WAIT_MAX != 0) && waiting && !mem_done &&
                    (wait_cnt == MEM_WAIT_MAX - 1);

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= next;
      ovf_q    <= wait_ovf;
      wait_cnt <= (waiting && !mem_done && !wait_ovf) ? wait_cnt + 32'd1 : '0;
    end
  end

  always_comb begin
    next = state;
    case (state)
      S_RESET: next = fetch_next;
      S_T0:    next = S_T1;
      S_T1:    if (mem_done) next = S_T2; else if (wait_ovf) next = fetch_next;
      S_T2:    next = S_T3;
      S_T3: begin
        if (alu_rr || alu_imm || muldiv || mem_op) next = S_T4;
        else if (op == OP_HALT)                    next = S_HALT;
        else                                       next = fetch_next;
      end
      S_T4:    next = S_T5;
      S_T5:    next = (muldiv || mem_op) ? S_T6 : fetch_next;
      S_T6: begin
        if (op == OP_LD) begin
          if (mem_done) next = S_T7; else if (wait_ovf) next = fetch_next;
        end else if (op == OP_ST) next = S_T7;
        else                      next = fetch_next;
      end
      S_T7: begin
        if (op == OP_ST && !mem_done) begin
          if (wait_ovf) next = fetch_next;
        end else next = fetch_next;
      end
      S_HALT:  next = S_HALT;
      default: next = S_RESET;
    endcase
  end

  always_comb begin
    PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; MDRread = 1'b0; Yin = 1'b0; Zin = 1'b0;
    Zhighout = 1'b0; Zlowout = 1'b0; HIin = 1'b0; HIout = 1'b0; LOin = 1'b0;
    LOout = 1'b0; Cout = 1'b0; ALUselect = ALU_ADD; mem_read = 1'b0; mem_write = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin_en = 1'b0; rout_en = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin mem_read = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (alu_rr || alu_imm) begin grb = 1'b1; rout_en = 1'b1; Yin = 1'b1; end
        else if (muldiv)       begin gra = 1'b1; rout_en = 1'b1; Yin = 1'b1; end
        else if (mem_op) begin
          // Rb = 0 selects a zero base: Y loads from an undriven bus.
          grb = 1'b1; rout_en = (IR[22:19] != 4'd0); Yin = 1'b1;
        end
        else if (op == OP_MFHI) begin HIout = 1'b1; gra = 1'b1; rin_en = 1'b1; end
        else if (op == OP_MFLO) begin LOout = 1'b1; gra = 1'b1; rin_en = 1'b1; end
      end
      S_T4: begin
        if (alu_rr)      begin grc = 1'b1; rout_en = 1'b1; Zin = 1'b1; ALUselect = alu_code(op); end
        else if (muldiv) begin grb = 1'b1; rout_en = 1'b1; Zin = 1'b1; ALUselect = alu_code(op); end
        else if (alu_imm || mem_op) begin Cout = 1'b1; Zin = 1'b1; ALUselect = ALU_ADD; end
      end
      S_T5: begin
        Zlowout = alu_rr || alu_imm || muldiv || mem_op;
        if (alu_rr || alu_imm) begin gra = 1'b1; rin_en = 1'b1; end
        LOin  = muldiv;
        MARin = mem_op;
      end
      S_T6: begin
        if (muldiv) begin Zhighout = 1'b1; HIin = 1'b1; end
        else if (op == OP_LD) begin mem_read = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
        else if (op == OP_ST) begin gra = 1'b1; rout_en = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        if (op == OP_LD)      begin MDRout = 1'b1; gra = 1'b1; rin_en = 1'b1; end
        else if (op == OP_ST) mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign run     = (state != S_RESET) && (state != S_HALT);
  assign illegal = ((state == S_T3) && !op_defined(op)) || ovf_q;

  select_encode u_sel (
    .regs     (IR[26:15]),
    .gra      (gra),
    .grb      (grb),
    .grc      (grc),
    .rin      (rin_en),
    .rout     (rout_en),
    .rin_vec  (Rin),
    .rout_vec (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: each instruction is expanded into an expected
// micro-step table and compared cycle by cycle against the DUT outputs.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] rin, rout;
    logic pcin, pcout, incpc, irin, marin, mdrin, mdrout, mdrread, yin, zin;
    logic zhighout, zlowout, hiin, hiout, loin, loout, cout;
    logic [3:0] alusel;
    logic mem_read, mem_write, run, illegal;
  } cw_t;

  logic        clock = 1'b0;
  logic        clear, mem_done, stop;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, MDRread, Yin, Zin;
  logic Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout;
  logic [3:0] ALUselect;
  logic mem_read, mem_write, run, illegal;

  int ntests = 0;
  int nfail  = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_done(mem_done), .stop(stop),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .MDRread(MDRread), .Yin(Yin),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .Cout(Cout), .ALUselect(ALUselect),
    .mem_read(mem_read), .mem_write(mem_write), .run(run), .illegal(illegal)
  );

  function automatic cw_t dut_cw();
    cw_t c;
    c.rin = Rin; c.rout = Rout; c.pcin = PCin; c.pcout = PCout; c.incpc = IncPC;
    c.irin = IRin; c.marin = MARin; c.mdrin = MDRin; c.mdrout = MDRout;
    c.mdrread = MDRread; c.yin = Yin; c.zin = Zin; c.zhighout = Zhighout;
    c.zlowout = Zlowout; c.hiin = HIin; c.hiout = HIout; c.loin = LOin;
    c.loout = LOout; c.cout = Cout; c.alusel = ALUselect; c.mem_read = mem_read;
    c.mem_write = mem_write; c.run = run; c.illegal = illegal;
    return c;
  endfunction

  function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0123};
  endfunction

  // Expands one instruction into its micro-step table and checks it cycle by
  // cycle. fd/dd: cycle in which mem_done rises in the fetch/data wait.
  // Returns early (in RESET) when clear is applied at step clear_at.
  task automatic exec_instr(input logic [31:0] ir, input int fd, input int dd,
                            input bit stop_last, input int clear_at, input string name);
    cw_t q[$];
    bit  wq[$];
    cw_t b, c;
    int  op, ra, rb, rc, idx, wcnt, wno, dly;
    bit  w, last;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    IR = ir;
    b = '0; b.run = 1'b1;
    c = b; c.pcout = 1; c.marin = 1; c.incpc = 1;        q.push_back(c); wq.push_back(0);
    c = b; c.mem_read = 1; c.mdrread = 1; c.mdrin = 1;   q.push_back(c); wq.push_back(1);
    c = b; c.mdrout = 1; c.irin = 1;                     q.push_back(c); wq.push_back(0);
    case (op)
      3, 4, 5, 6, 12: begin
        c = b; c.rout = 16'(1 << rb); c.yin = 1;         q.push_back(c); wq.push_back(0);
        c = b; c.zin = 1;
        if (op == 12) c.cout = 1;
        else begin
          c.rout = 16'(1 << rc);
          c.alusel = (op == 3) ? 4'd0 : (op == 4) ? 4'd1 : (op == 5) ? 4'd2 : 4'd3;
        end
        q.push_back(c); wq.push_back(0);
        c = b; c.zlowout = 1; c.rin = 16'(1 << ra);      q.push_back(c); wq.push_back(0);
      end
      15, 16: begin
        c = b; c.rout = 16'(1 << ra); c.yin = 1;         q.push_back(c); wq.push_back(0);
        c = b; c.rout = 16'(1 << rb); c.zin = 1;
        c.alusel = (op == 15) ? 4'd4 : 4'd5;             q.push_back(c); wq.push_back(0);
        c = b; c.zlowout = 1; c.loin = 1;                q.push_back(c); wq.push_back(0);
        c = b; c.zhighout = 1; c.hiin = 1;               q.push_back(c); wq.push_back(0);
      end
      0, 2: begin
        c = b; c.rout = (rb == 0) ? 16'h0 : 16'(1 << rb); c.yin = 1; q.push_back(c); wq.push_back(0);
        c = b; c.cout = 1; c.zin = 1;                    q.push_back(c); wq.push_back(0);
        c = b; c.zlowout = 1; c.marin = 1;               q.push_back(c); wq.push_back(0);
        if (op == 0) begin
          c = b; c.mem_read = 1; c.mdrread = 1; c.mdrin = 1; q.push_back(c); wq.push_back(1);
          c = b; c.mdrout = 1; c.rin = 16'(1 << ra);     q.push_back(c); wq.push_back(0);
        end else begin
          c = b; c.rout = 16'(1 << ra); c.mdrin = 1;     q.push_back(c); wq.push_back(0);
          c = b; c.mem_write = 1;                        q.push_back(c); wq.push_back(1);
        end
      end
      24: begin c = b; c.hiout = 1; c.rin = 16'(1 << ra); q.push_back(c); wq.push_back(0); end
      25: begin c = b; c.loout = 1; c.rin = 16'(1 << ra); q.push_back(c); wq.push_back(0); end
      26, 27: begin c = b;                               q.push_back(c); wq.push_back(0); end
      default: begin c = b; c.illegal = 1;               q.push_back(c); wq.push_back(0); end
    endcase
    idx = 0; wcnt = 0; wno = 0;
    while (q.size() > 0) begin
      w    = wq[0];
      last = (q.size() == 1);
      dly  = (wno == 0) ? fd : dd;
      mem_done = w ? (wcnt + 1 >= dly) : 1'($urandom_range(0, 1));
      stop     = (last && !(w && !mem_done)) ? stop_last : 1'($urandom_range(0, 1));
      clear    = (idx == clear_at);
      @(negedge clock);
      ntests++;
      if (dut_cw() !== q[0]) begin
        nfail++;
        $display("FAIL %s step %0d: got %h expected %h", name, idx, dut_cw(), q[0]);
      end
      @(posedge clock); #1;
      if (clear) begin
        clear = 1'b0; stop = 1'b0;
        return;
      end
      if (w && !mem_done) wcnt++;
      else begin
        if (w) wno++;
        wcnt = 0;
        void'(q.pop_front()); void'(wq.pop_front());
      end
      idx++;
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    cw_t z = '0;
    clear = 1'b1; stop = 1'b0; mem_done = 1'b0; IR = '0;
    @(posedge clock); #1;
    @(negedge clock);
    ntests++;
    if (dut_cw() !== z) begin nfail++; $display("FAIL reset_hold: got %h expected %h", dut_cw(), z); end
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    ntests++;
    if (dut_cw() !== z) begin nfail++; $display("FAIL reset_state: got %h expected %h", dut_cw(), z); end
    @(posedge clock); #1;
  endtask

  task automatic test_alu();
    exec_instr(32'h1891_8000, 1, 1, 0, -1, "add_r1_r2_r3");
    exec_instr(enc(5, 9, 10, 11), 2, 1, 0, -1, "and");
    exec_instr(enc(12, 15, 0, 0), 1, 1, 0, -1, "addi");
  endtask

  task automatic test_ld_st();
    exec_instr(enc(0, 4, 2, 0), 1, 3, 0, -1, "ld_r4_r2");
    exec_instr(enc(2, 5, 0, 0), 1, 4, 0, -1, "st_r5_r0");
    exec_instr(enc(2, 0, 15, 0), 3, 1, 0, -1, "st_r0_r15");
  endtask

  task automatic test_muldiv();
    exec_instr(enc(15, 6, 7, 0), 1, 1, 0, -1, "mul_r6_r7");
    exec_instr(enc(16, 1, 14, 0), 1, 1, 0, -1, "div");
    exec_instr(enc(24, 3, 0, 0), 1, 1, 0, -1, "mfhi");
    exec_instr(enc(25, 12, 0, 0), 1, 1, 0, -1, "mflo");
  endtask

  task automatic test_illegal();
    exec_instr(enc(31, 1, 2, 3), 1, 1, 0, -1, "undef_11111");
    exec_instr(enc(26, 0, 0, 0), 1, 1, 0, -1, "nop_after_undef");
  endtask

  task automatic test_clear_mid();
    cw_t z = '0;
    exec_instr(enc(4, 1, 2, 3), 1, 1, 0, 4, "sub_clear_t4");
    @(negedge clock);
    ntests++;
    if (dut_cw() !== z) begin nfail++; $display("FAIL clear_mid: got %h expected %h", dut_cw(), z); end
    @(posedge clock); #1;
  endtask

  task automatic test_stop();
    cw_t z = '0;
    exec_instr(enc(3, 1, 2, 3), 1, 1, 1, -1, "add_stop");
    for (int i = 0; i < 3; i++) begin
      mem_done = 1'($urandom_range(0, 1));
      @(negedge clock);
      ntests++;
      if (dut_cw() !== z) begin nfail++; $display("FAIL stop_halt cyc %0d: got %h expected %h", i, dut_cw(), z); end
      @(posedge clock); #1;
    end
    clear = 1'b1; stop = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    ntests++;
    if (dut_cw() !== z) begin nfail++; $display("FAIL stop_reset: got %h expected %h", dut_cw(), z); end
    @(posedge clock); #1;
  endtask

  task automatic test_halt();
    cw_t z = '0;
    exec_instr(enc(27, 0, 0, 0), 1, 1, 0, -1, "halt");
    for (int i = 0; i < 10; i++) begin
      mem_done = 1'($urandom_range(0, 1));
      stop     = 1'($urandom_range(0, 1));
      @(negedge clock);
      ntests++;
      if (dut_cw() !== z) begin nfail++; $display("FAIL halt cyc %0d: got %h expected %h", i, dut_cw(), z); end
      @(posedge clock); #1;
    end
    clear = 1'b1; stop = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    ntests++;
    if (dut_cw() !== z) begin nfail++; $display("FAIL halt_reset: got %h expected %h", dut_cw(), z); end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int known[12] = '{0, 2, 3, 4, 5, 6, 12, 15, 16, 24, 25, 26};
    int op;
    bit ok;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do begin
          op = int'($urandom_range(0, 31));
          ok = (op != 27);
          foreach (known[k]) if (known[k] == op) ok = 1'b0;
        end while (!ok);
      end else op = known[$urandom_range(0, 11)];
      exec_instr(enc(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15))),
                 int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 0, -1, "random");
    end
    exec_instr(enc(26, 0, 0, 0), 1, 1, 0, -1, "final_nop");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ld_st();
    test_muldiv();
    test_illegal();
    test_clear_mid();
    test_stop();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
